product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream stage of the registered signed multiplier. Consumes a stream of signed 2N-bit products and sums a programmed number of them into a guarded accumulator.
- Presents each finished sum through a valid/ready output, so dot products and FIR taps can be built around the multiplier.
- Sits between the multiplier's output register and the result sink or bus.

Parameters:
- N, 32, multiplier operand width; the product input is 2*N bits.
- GUARD, 8, guard bits added above the product width; accumulator width is ACC_W = 2*N+GUARD.
- LW, 16, width of the term-count field.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; begins a frame when in IDLE
- len  input  LW  number of products in the frame; sampled on an accepted start
- prod_valid  input  1  product_in is valid
- prod_in  input  2*N  signed product
- prod_ready  output  1  stage accepts product_in this cycle
- acc_out  output  ACC_W  signed accumulated sum, held while out_valid
- out_valid  output  1  acc_out is valid
- out_ready  input  1  sink accepts acc_out
- overflow  output  1  sticky per frame; the signed sum wrapped in ACC_W
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high; clk and reset as named above): state=IDLE, acc_out=0, out_valid=0, prod_ready=0, overflow=0, busy=0, remaining-count=0.
- Reset asserted mid-frame aborts the frame; no partial result is emitted.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 and len!=0: acc<=0, overflow<=0, cnt<=len, go to ACCUM.
  - start=1 and len==0: acc<=0, overflow<=0, go directly to HOLD. An empty frame yields 0.
  - start=0: stay in IDLE.
- ACCUM:
  - prod_ready=1.
  - A transfer occurs when prod_valid&&prod_ready.
  - On each transfer: acc <= acc + sign_extend(prod_in, ACC_W), and cnt <= cnt-1.
  - The transfer with cnt==1 moves to HOLD.
  - No transfer: acc and cnt hold.
- HOLD:
  - out_valid=1 and prod_ready=0.
  - acc_out and overflow are stable until a handshake.
  - out_valid&&out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - acc_out and overflow keep their last values in IDLE until the next accepted start.
- start is ignored outside IDLE. start and out_ready high together in HOLD: the handshake completes and start is ignored; a new start needs IDLE.
- Latency: out_valid rises on the cycle after the last product transfer. With prod_valid held high, a len=K frame takes K cycles in ACCUM, then HOLD. Minimum frame-to-frame period is K+2 cycles.
- Arithmetic:
  - Two's-complement wrap at ACC_W.
  - overflow is set when both addends have equal sign and the sum's sign differs.
  - Once set, overflow stays set until the next frame start.
- Products presented while not in ACCUM are not consumed. The upstream stage must hold prod_valid and prod_in until it sees prod_ready.
- len wider than the actual stream is not an error; the block waits indefinitely in ACCUM.

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE, ACCUM, HOLD);
  - the default constants N=32, GUARD=8, LW=16;
  - the ACC_W derivation.
- One natural sub-module, acc_add_ovf: combinational signed add with sign-extension and overflow detect, width ACC_W. The FSM, counter and registers stay in the top module.

Test Plan:
- Reset and idle: reset high for 2 cycles → all outputs 0, prod_ready=0, busy=0. Start with len=3 and products 5, -2, 7 streamed back-to-back → out_valid on the cycle after the third transfer, acc_out=10, overflow=0.
- Backpressure on both sides:
  - Stimulus: len=4, products 100, 200, 300, 400; prod_valid toggled randomly; out_ready held low for 5 cycles.
  - Response: acc_out=1000 held stable and out_valid held high until out_ready, then busy drops.
- Empty frame: start with len=0 → HOLD next cycle, acc_out=0, out_valid=1; cycles with prod_valid=1 see no transfer.
- Overflow with GUARD=0: four products each equal to the max positive 64-bit value → overflow=1 at the result, acc_out equals the wrapped sum. A following frame of len=1, product 3 → overflow=0, acc_out=3.
- Abort and ignored start:
  - Reset asserted after 2 of 5 transfers → IDLE next cycle, no out_valid. A new frame of len=2, products -1 and -1 → acc_out=-2.
  - start pulsed during ACCUM → no effect on cnt or acc.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator.
package product_accumulator_pkg;

    localparam int unsigned N_DEF     = 32;
    localparam int unsigned GUARD_DEF = 8;
    localparam int unsigned LW_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Accumulator width: full product width plus guard bits.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned guard);
        return 2 * n + guard;
    endfunction

endpackage

// File: rtl/product_accumulator_add_ovf.sv
// Combinational signed add of a sign-extended product into the accumulator, with wrap detect.
module acc_add_ovf #(
    parameter int unsigned ACC_W = 72,
    parameter int unsigned PW    = 64
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [PW-1:0]    prod_in,
    output logic [ACC_W-1:0] sum_c,
    output logic             ovf_c
);

    logic signed [ACC_W-1:0] prod_ext;

    // Sign-extend the product to accumulator width.
    assign prod_ext = ACC_W'($signed(prod_in));

    assign sum_c = acc_in + prod_ext;

    // Equal-signed addends producing a different-signed sum means the result wrapped.
    assign ovf_c = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_c[ACC_W-1] != acc_in[ACC_W-1]);

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of signed products and hands the total out over valid/ready.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned GUARD = GUARD_DEF,
    parameter int unsigned LW    = LW_DEF,
    localparam int unsigned PW    = 2 * N,
    localparam int unsigned ACC_W = acc_width(N, GUARD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic             prod_valid,
    input  logic [PW-1:0]    prod_in,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_d;
    logic [ACC_W-1:0] sum_c;
    logic             add_ovf_c;
    logic             xfer_c;

    acc_add_ovf #(
        .ACC_W (ACC_W),
        .PW    (PW)
    ) u_add (
        .acc_in  (acc_out),
        .prod_in (prod_in),
        .sum_c   (sum_c),
        .ovf_c   (add_ovf_c)
    );

    // prod_ready is high exactly while in ACCUM, so it qualifies the transfer directly.
    assign xfer_c = prod_valid && prod_ready;

    // Next-state, accumulator, counter and sticky-overflow update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_out;
        cnt_d   = cnt_q;
        ovf_d   = overflow;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_ACCUM: begin
                if (xfer_c) begin
                    acc_d = sum_c;
                    ovf_d = overflow | add_ovf_c;
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and handshake outputs, all registered off the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_out    <= '0;
            overflow   <= 1'b0;
            prod_ready <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_out    <= acc_d;
            overflow   <= ovf_d;
            prod_ready <= (state_d == ST_ACCUM);
            out_valid  <= (state_d == ST_HOLD);
            busy       <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a default-width instance and a zero-guard instance share stimulus.
module tb_product_accumulator;

    localparam int unsigned N   = 32;
    localparam int unsigned LW  = 16;
    localparam int unsigned PW  = 2 * N;
    localparam int unsigned AW8 = 2 * N + 8;
    localparam int unsigned AW0 = 2 * N;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [LW-1:0]  len;
    logic           prod_valid;
    logic [PW-1:0]  prod_in;
    logic           out_ready;

    logic           prod_ready8, out_valid8, overflow8, busy8;
    logic [AW8-1:0] acc_out8;
    logic           prod_ready0, out_valid0, overflow0, busy0;
    logic [AW0-1:0] acc_out0;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [AW8-1:0] acc; logic ovf; } exp8_t;
    typedef struct { logic [AW0-1:0] acc; logic ovf; } exp0_t;
    exp8_t q8[$];
    exp0_t q0[$];

    product_accumulator #(.N(N), .GUARD(8), .LW(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_in(prod_in), .prod_ready(prod_ready8),
        .acc_out(acc_out8), .out_valid(out_valid8), .out_ready(out_ready),
        .overflow(overflow8), .busy(busy8)
    );

    product_accumulator #(.N(N), .GUARD(0), .LW(LW)) dut_g0 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_in(prod_in), .prod_ready(prod_ready0),
        .acc_out(acc_out0), .out_valid(out_valid0), .out_ready(out_ready),
        .overflow(overflow0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [AW8-1:0] act, input logic [AW8-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic signed [AW8-1:0] e8, input logic o8,
                            input logic signed [AW0-1:0] e0, input logic o0);
        exp8_t a;
        exp0_t b;
        a.acc = e8; a.ovf = o8;
        b.acc = e0; b.ovf = o0;
        q8.push_back(a);
        q0.push_back(b);
    endtask

    // Monitor for the guarded instance: compare at each output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid8 && out_ready) begin
            if (q8.size() == 0) begin
                check("g8_unexpected_result", 1, 0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                check("g8_acc_out", acc_out8, e.acc);
                check("g8_overflow", AW8'(overflow8), AW8'(e.ovf));
            end
        end
    end

    // Monitor for the zero-guard instance.
    always @(negedge clk) begin
        if (!reset && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                check("g0_unexpected_result", 1, 0);
            end else begin
                exp0_t e;
                e = q0.pop_front();
                check("g0_acc_out", AW8'(acc_out0), AW8'(e.acc));
                check("g0_overflow", AW8'(overflow0), AW8'(e.ovf));
            end
        end
    end

    task automatic start_frame(input logic [LW-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Present one product, optionally after idle gap cycles, and wait for its transfer.
    task automatic send(input logic signed [PW-1:0] p, input int gap);
        int budget;
        prod_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        prod_valid = 1'b1;
        prod_in    = p;
        budget     = 0;
        while (!prod_ready8 && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) check("send_timeout", 1, 0);
        tick();
        prod_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0;
        prod_valid = 1'b0; prod_in = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_acc_out", acc_out8, 0);
        check("rst_out_valid", AW8'(out_valid8), 0);
        check("rst_prod_ready", AW8'(prod_ready8), 0);
        check("rst_busy", AW8'(busy8), 0);
        check("rst_overflow", AW8'(overflow8), 0);
        reset = 1'b0;
        tick();

        // Basic frame: 5 - 2 + 7, back to back.
        push_exp(10, 0, 10, 0);
        start_frame(3);
        check("accum_prod_ready", AW8'(prod_ready8), 1);
        send(5, 0); send(-2, 0); send(7, 0);
        check("basic_latency_valid", AW8'(out_valid8), 1);
        tick();
        check("basic_done_idle", AW8'(busy8), 0);

        // Backpressure on both sides.
        out_ready = 1'b0;
        push_exp(1000, 0, 1000, 0);
        start_frame(4);
        send(100, $urandom_range(0, 2)); send(200, $urandom_range(0, 2));
        send(300, $urandom_range(0, 2)); send(400, $urandom_range(0, 2));
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", AW8'(out_valid8), 1);
            check("bp_hold_acc", acc_out8, 1000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_busy_drop", AW8'(busy8), 0);
        check("bp_valid_drop", AW8'(out_valid8), 0);

        // Empty frame; products offered in HOLD must not be consumed.
        out_ready = 1'b0;
        push_exp(0, 0, 0, 0);
        start_frame(0);
        check("empty_valid", AW8'(out_valid8), 1);
        prod_valid = 1'b1; prod_in = 64'd99;
        tick(); tick();
        check("empty_no_ready", AW8'(prod_ready8), 0);
        check("empty_acc", acc_out8, 0);
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        tick();

        // Overflow: four max-positive products wrap only the zero-guard instance.
        push_exp(72'h1_FFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        start_frame(4);
        for (int i = 0; i < 4; i++) send(64'sh7FFF_FFFF_FFFF_FFFF, 0);
        tick();
        push_exp(3, 0, 3, 0);
        start_frame(1);
        send(3, 0);
        tick();

        // Reset after 2 of 5 transfers aborts with no result.
        start_frame(5);
        send(11, 0); send(22, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", AW8'(out_valid8), 0);
        check("abort_busy", AW8'(busy8), 0);
        check("abort_acc", acc_out8, 0);
        tick(); tick();
        check("abort_still_idle", AW8'(out_valid8), 0);
        push_exp(-2, 0, -2, 0);
        start_frame(2);
        send(-1, 0); send(-1, 0);
        tick();

        // start during ACCUM is ignored: frame still ends after 3 products.
        push_exp(6, 0, 6, 0);
        start_frame(3);
        send(1, 0);
        start = 1'b1; len = 16'd7;
        tick();
        start = 1'b0;
        send(2, 0);
        check("ign_start_busy", AW8'(out_valid8), 0);
        send(3, 0);
        check("ign_start_valid", AW8'(out_valid8), 1);
        tick(); tick();

        check("q8_drained", AW8'(q8.size()), 0);
        check("q0_drained", AW8'(q0.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so a stuck handshake cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
